csa_accum: RTL and testbench
============================

CSA_ACCUM -- requirements
Module: csa_accum

Interface
REQ-001 The block SHALL have parameter W, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter CNT_W, default 8, giving the beat-counter width.
REQ-003 The block SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit, asynchronous active-low reset.
REQ-005 The block SHALL have port clr, input, 1 bit, synchronous packet abort.
REQ-006 The block SHALL have port in_valid, input, 1 bit, an upstream operand is present.
REQ-007 The block SHALL have port in_ready, output, 1 bit, the block accepts an operand this cycle.
REQ-008 The block SHALL have port in_data, input, W bits, the operand.
REQ-009 The block SHALL have port in_sub, input, 1 bit; when 1, subtract in_data instead of adding it.
REQ-010 The block SHALL have port in_last, input, 1 bit, the final operand of the packet.
REQ-011 The block SHALL have port out_valid, output, 1 bit, a carry-save result is presented.
REQ-012 The block SHALL have port out_ready, input, 1 bit, the downstream adder consumes the result.
REQ-013 The block SHALL have port out_a, output, W bits, the sum vector; it drives adder input a.
REQ-014 The block SHALL have port out_b, output, W bits, the shifted carry vector; it drives adder input b, with adder c_in tied to 0.
REQ-015 The block SHALL have port out_count, output, CNT_W bits, the number of beats accepted in the packet.
REQ-016 The block SHALL have port out_sat, output, 1 bit, set when out_count saturated.

Function
REQ-017 The block SHALL have two states: ACC (accepting) and OUT (presenting).
REQ-018 The block SHALL drive in_ready = (state==ACC) and out_valid = (state==OUT); both are registered-state decodes.
REQ-019 A beat SHALL be accepted when in_valid && in_ready.
- Operand: x' = in_sub ? ~in_data : in_data.
- Update: S <= S^C^x'.
- Update: C <= {maj(S,C,x')[W-2:0], in_sub}.
REQ-020 Invariant: (S + C) mod 2^W SHALL equal the signed packet sum mod 2^W; carries out of bit W-1 are discarded, giving wrap-around.
REQ-021 Each accepted beat SHALL increment the count, which saturates at 2^CNT_W-1; an accepted beat while the count is already saturated SHALL set sat, and sat is sticky until the packet ends.
REQ-022 An accepted beat with in_last=1 SHALL move the state to OUT, so out_valid is high the cycle after acceptance (latency 1).
REQ-023 In OUT, out_a=S, out_b=C, out_count and out_sat SHALL be held stable until out_valid && out_ready.
REQ-024 On out_valid && out_ready, the block SHALL clear S, C, count and sat to 0 and return to ACC; in_ready is high the next cycle.
REQ-025 Input and output handshakes are never simultaneous, because in_ready=0 in OUT; inputs presented in OUT SHALL be ignored.
REQ-026 clr=1 SHALL clear S, C, count and sat to 0 and move the state to ACC in any state, with priority over both handshakes; a beat presented with clr=1 is not accepted.
REQ-027 out_a and out_b SHALL be driven from registers and SHALL read 0 in ACC outside a packet.

Reset
REQ-028 When rst=0, the block SHALL asynchronously set state=ACC and S=C=0, count=0 and sat=0, giving in_ready=1, out_valid=0, out_a=out_b=0, out_count=0 and out_sat=0.
REQ-029 Reset mid-packet or during OUT SHALL discard all partial results; the first beat after rst deasserts starts a new packet.

Verification (W=8, CNT_W=8 unless stated)
REQ-030 Beats 0x05, then 0x03 with last, out_ready=1 -> next cycle out_valid=1, out_a=0x06, out_b=0x02, sum 0x08, out_count=2, out_sat=0.
REQ-031 Beats 0x10, then sub 0x01 with last -> out_a+out_b mod 256 = 0x0F, out_count=2.
REQ-032 Beats 0xFF, then 0x02 with last -> sum wraps to 0x01; no error flag.
REQ-033 Result presented with out_ready held 0 for 3 cycles -> out_a/out_b/out_count stable and in_ready=0 throughout; accepted on the 4th cycle, then in_ready=1 one cycle later.
REQ-034 Three beats, clr pulsed before last, then beat 0x07 with last -> sum 0x07, out_count=1.
REQ-035 CNT_W=2, five beats of 0x01 -> sum 0x05, out_count=3, out_sat=1.
REQ-036 rst asserted during OUT -> out_valid=0 immediately (asynchronous), all outputs 0, in_ready=1.

Source files
------------

// File: rtl/csa_accum.sv
// csa_accum: carry-save packet accumulator.
// Sums a packet of signed operands into a sum/carry vector pair. Each beat
// costs one full-adder row, with no carry chain. A downstream adder with
// c_in=0 resolves out_a + out_b.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-low reset
//   clr        synchronous packet abort, overrides both handshakes
//   in_valid   operand present           in_ready  accepting (state ACC)
//   in_data    operand                   in_sub    subtract in_data
//   in_last    final operand of packet
//   out_valid  result presented (OUT)    out_ready downstream consumes result
//   out_a      sum vector                out_b     shifted carry vector
//   out_count  beats accepted (saturating)
//   out_sat    count saturated during packet (sticky)
module csa_accum #(
   parameter int unsigned W     = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [W-1:0]     in_data,
   input  logic             in_sub,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [W-1:0]     out_a,
   output logic [W-1:0]     out_b,
   output logic [CNT_W-1:0] out_count,
   output logic             out_sat
);

   localparam int unsigned CW = W - 1;

   typedef enum logic {
      ACC = 1'b0,
      OUT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [W-1:0]     s_q, s_nxt;
   logic [W-1:0]     c_q, c_nxt;
   logic [CNT_W-1:0] cnt_q, cnt_nxt;
   logic             sat_q, sat_nxt;

   logic [W-1:0]     x_op_c;
   logic [CW-1:0]    maj_c;
   logic             cnt_full_c;

   // Subtraction as ~x + 1. The +1 enters through the free carry LSB.
   assign x_op_c = in_sub ? ~in_data : in_data;

   // Majority of the low W-1 bits. The carry out of bit W-1 is discarded, so
   // the sum wraps around.
   assign maj_c = (s_q[CW-1:0] & c_q[CW-1:0])
                | (s_q[CW-1:0] & x_op_c[CW-1:0])
                | (c_q[CW-1:0] & x_op_c[CW-1:0]);

   assign cnt_full_c = &cnt_q;

   // Next-state and datapath update.
   always_comb begin
      state_nxt = state;
      s_nxt     = s_q;
      c_nxt     = c_q;
      cnt_nxt   = cnt_q;
      sat_nxt   = sat_q;

      if (clr) begin
         state_nxt = ACC;
         s_nxt     = '0;
         c_nxt     = '0;
         cnt_nxt   = '0;
         sat_nxt   = 1'b0;
      end else begin
         case (state)
            ACC: begin
               if (in_valid) begin
                  s_nxt = s_q ^ c_q ^ x_op_c;
                  c_nxt = {maj_c, in_sub};
                  if (cnt_full_c) begin
                     sat_nxt = 1'b1;
                  end else begin
                     cnt_nxt = cnt_q + CNT_W'(1);
                  end
                  if (in_last) begin
                     state_nxt = OUT;
                  end
               end
            end
            OUT: begin
               if (out_ready) begin
                  state_nxt = ACC;
                  s_nxt     = '0;
                  c_nxt     = '0;
                  cnt_nxt   = '0;
                  sat_nxt   = 1'b0;
               end
            end
            default: state_nxt = ACC;
         endcase
      end
   end

   // State register. The handshake flags are registered copies of the
   // state decode.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= ACC;
         s_q       <= '0;
         c_q       <= '0;
         cnt_q     <= '0;
         sat_q     <= 1'b0;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
      end else begin
         state     <= state_nxt;
         s_q       <= s_nxt;
         c_q       <= c_nxt;
         cnt_q     <= cnt_nxt;
         sat_q     <= sat_nxt;
         in_ready  <= (state_nxt == ACC);
         out_valid <= (state_nxt == OUT);
      end
   end

   assign out_a     = s_q;
   assign out_b     = c_q;
   assign out_count = cnt_q;
   assign out_sat   = sat_q;

endmodule

// File: tb/tb_csa_accum.sv
// Directed bench for csa_accum. Instance u0 uses W=8 and CNT_W=8. Instance u1
// uses W=8 and CNT_W=2 for the saturation case.
module tb_csa_accum;

   logic       clk;
   logic       rst;
   // u0 signals
   logic       clr, in_valid, in_ready, in_sub, in_last, out_valid, out_ready, out_sat;
   logic [7:0] in_data, out_a, out_b, out_count;
   // u1 signals
   logic       k_clr, k_valid, k_ready, k_sub, k_last, k_ovalid, k_oready, k_sat;
   logic [7:0] k_data, k_a, k_b;
   logic [1:0] k_count;

   int tests = 0;
   int fails = 0;

   logic [7:0] hold_a, hold_b, hold_cnt;

   csa_accum #(.W(8), .CNT_W(8)) u0 (
      .clk(clk), .rst(rst), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
      .in_sub(in_sub), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_count(out_count), .out_sat(out_sat)
   );

   csa_accum #(.W(8), .CNT_W(2)) u1 (
      .clk(clk), .rst(rst), .clr(k_clr),
      .in_valid(k_valid), .in_ready(k_ready), .in_data(k_data),
      .in_sub(k_sub), .in_last(k_last),
      .out_valid(k_ovalid), .out_ready(k_oready),
      .out_a(k_a), .out_b(k_b), .out_count(k_count), .out_sat(k_sat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // One u0 beat, held for a single clock edge. Sampling happens 1 time unit
   // after that edge.
   task automatic beat(input logic [7:0] d, input logic sub, input logic last);
      in_valid = 1'b1; in_data = d; in_sub = sub; in_last = last;
      @(posedge clk); #1;
      in_valid = 1'b0; in_sub = 1'b0; in_last = 1'b0; in_data = '0;
   endtask

   task automatic kbeat(input logic [7:0] d, input logic last);
      k_valid = 1'b1; k_data = d; k_last = last;
      @(posedge clk); #1;
      k_valid = 1'b0; k_last = 1'b0; k_data = '0;
   endtask

   // Consume the presented u0 result, then confirm the block is back in ACC
   // with its state cleared.
   task automatic drain(input string tag);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check({tag, "_ready_after"}, 32'(in_ready), 32'd1);
      check({tag, "_valid_after"}, 32'(out_valid), 32'd0);
      check({tag, "_a_cleared"}, 32'(out_a), 32'd0);
   endtask

   initial begin
      rst = 1'b0;
      clr = 0; in_valid = 0; in_sub = 0; in_last = 0; in_data = '0; out_ready = 0;
      k_clr = 0; k_valid = 0; k_sub = 0; k_last = 0; k_data = '0; k_oready = 0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_a", 32'(out_a), 32'd0);
      check("rst_out_b", 32'(out_b), 32'd0);
      check("rst_count", 32'(out_count), 32'd0);
      check("rst_sat", 32'(out_sat), 32'd0);
      rst = 1'b1;
      @(posedge clk); #1;

      // 5 + 3: S=0x06, C=0x02. out_ready is high, so the result shows for one cycle.
      out_ready = 1'b1;
      beat(8'h05, 1'b0, 1'b0);
      check("t1_mid_valid", 32'(out_valid), 32'd0);
      beat(8'h03, 1'b0, 1'b1);
      check("t1_valid", 32'(out_valid), 32'd1);
      check("t1_ready", 32'(in_ready), 32'd0);
      check("t1_a", 32'(out_a), 32'h06);
      check("t1_b", 32'(out_b), 32'h02);
      check("t1_sum", 32'(8'(out_a + out_b)), 32'h08);
      check("t1_count", 32'(out_count), 32'd2);
      check("t1_sat", 32'(out_sat), 32'd0);
      @(posedge clk); #1;
      out_ready = 1'b0;
      check("t1_ready_after", 32'(in_ready), 32'd1);
      check("t1_valid_after", 32'(out_valid), 32'd0);
      check("t1_b_cleared", 32'(out_b), 32'd0);

      // 0x10 - 0x01: S=0xEE, C=0x21, sum 0x0F.
      beat(8'h10, 1'b0, 1'b0);
      beat(8'h01, 1'b1, 1'b1);
      check("t2_a", 32'(out_a), 32'hEE);
      check("t2_b", 32'(out_b), 32'h21);
      check("t2_sum", 32'(8'(out_a + out_b)), 32'h0F);
      check("t2_count", 32'(out_count), 32'd2);
      drain("t2");

      // 0xFF + 0x02 wraps to 0x01. Result is held 3 cycles while beats are offered.
      beat(8'hFF, 1'b0, 1'b0);
      beat(8'h02, 1'b0, 1'b1);
      check("t3_sum", 32'(8'(out_a + out_b)), 32'h01);
      check("t3_a", 32'(out_a), 32'hFD);
      check("t3_b", 32'(out_b), 32'h04);
      hold_a = out_a; hold_b = out_b; hold_cnt = out_count;
      in_valid = 1'b1; in_data = 8'h40; in_last = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         check("t4_hold_valid", 32'(out_valid), 32'd1);
         check("t4_hold_ready", 32'(in_ready), 32'd0);
         check("t4_hold_a", 32'(out_a), 32'(hold_a));
         check("t4_hold_b", 32'(out_b), 32'(hold_b));
         check("t4_hold_cnt", 32'(out_count), 32'(hold_cnt));
      end
      in_valid = 1'b0; in_data = '0; in_last = 1'b0;
      drain("t4");

      // Abort: 3 beats, clr, a beat offered together with clr, then 0x07 last.
      beat(8'h01, 1'b0, 1'b0);
      beat(8'h02, 1'b0, 1'b0);
      beat(8'h03, 1'b0, 1'b0);
      check("t5_partial_cnt", 32'(out_count), 32'd3);
      clr = 1'b1;
      beat(8'h20, 1'b0, 1'b1);
      clr = 1'b0;
      check("t5_clr_cnt", 32'(out_count), 32'd0);
      check("t5_clr_a", 32'(out_a), 32'd0);
      check("t5_clr_valid", 32'(out_valid), 32'd0);
      beat(8'h07, 1'b0, 1'b1);
      check("t5_sum", 32'(8'(out_a + out_b)), 32'h07);
      check("t5_count", 32'(out_count), 32'd1);
      // clr also leaves OUT.
      clr = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      check("t5_clr_out_valid", 32'(out_valid), 32'd0);
      check("t5_clr_out_ready", 32'(in_ready), 32'd1);

      // Saturation on the CNT_W=2 instance: 5 x 0x01 gives S=0x01, C=0x04.
      for (int i = 0; i < 4; i++) kbeat(8'h01, 1'b0);
      kbeat(8'h01, 1'b1);
      check("t6_valid", 32'(k_ovalid), 32'd1);
      check("t6_sum", 32'(8'(k_a + k_b)), 32'h05);
      check("t6_b", 32'(k_b), 32'h04);
      check("t6_count", 32'(k_count), 32'd3);
      check("t6_sat", 32'(k_sat), 32'd1);
      k_oready = 1'b1;
      @(posedge clk); #1;
      k_oready = 1'b0;
      check("t6_sat_cleared", 32'(k_sat), 32'd0);
      check("t6_cnt_cleared", 32'(k_count), 32'd0);

      // Reset while presenting. The effect is immediate and all partial state is discarded.
      beat(8'h11, 1'b0, 1'b0);
      beat(8'h22, 1'b0, 1'b1);
      check("t7_pre_valid", 32'(out_valid), 32'd1);
      #2 rst = 1'b0;
      #1;
      check("t7_valid", 32'(out_valid), 32'd0);
      check("t7_ready", 32'(in_ready), 32'd1);
      check("t7_a", 32'(out_a), 32'd0);
      check("t7_b", 32'(out_b), 32'd0);
      check("t7_count", 32'(out_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk); #1;
      beat(8'h09, 1'b0, 1'b1);
      check("t7_new_sum", 32'(8'(out_a + out_b)), 32'h09);
      check("t7_new_count", 32'(out_count), 32'd1);
      drain("t7");

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
